// File: rtl/generador_pulso.sv
// Button auto-repeat pulse generator: one pulse per press, then repeats while held.
// Optional feature macro: GENERADOR_PULSO_AUTO_REPEAT_EN (undefined = single pulse per press).
module generador_pulso #(
    parameter int RETARDO_INICIAL    = 50_000_000,
    parameter int PERIODO_REPETICION = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    input  logic habilitar,
    output logic salida,
    output logic sostenido
);

    if (RETARDO_INICIAL < 2 || PERIODO_REPETICION < 2) begin : g_param_invalido
        $error("generador_pulso: RETARDO_INICIAL and PERIODO_REPETICION must be >= 2");
    end

    logic entrada_q;
    logic salida_q, salida_d;

    // entrada_q resets to 1 so a button already held at reset release is not a press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entrada_q <= 1'b1;
            salida_q  <= 1'b0;
        end else begin
            entrada_q <= entrada;
            salida_q  <= salida_d;
        end
    end

    assign salida = salida_q;

`ifdef GENERADOR_PULSO_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        ESPERA = 2'd1,
        REPITE = 2'd2
    } estado_t;

    localparam int CNT_MAX = (RETARDO_INICIAL > PERIODO_REPETICION) ? RETARDO_INICIAL
                                                                    : PERIODO_REPETICION;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TC_INICIAL = CNT_W'(RETARDO_INICIAL - 1);
    localparam logic [CNT_W-1:0] TC_PERIODO = CNT_W'(PERIODO_REPETICION - 1);

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sostenido_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= REPOSO;
            cnt_q       <= '0;
            sostenido_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            sostenido_q <= (estado_d == REPITE);
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        salida_d = 1'b0;
        // Release or disable wins over every state and suppresses the pulse
        if (!habilitar || !entrada) begin
            estado_d = REPOSO;
            cnt_d    = '0;
        end else begin
            unique case (estado_q)
                REPOSO: begin
                    if (!entrada_q) begin
                        salida_d = 1'b1;
                        cnt_d    = '0;
                        estado_d = ESPERA;
                    end
                end
                ESPERA: begin
                    if (cnt_q == TC_INICIAL) begin
                        salida_d = 1'b1;
                        cnt_d    = '0;
                        estado_d = REPITE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPITE: begin
                    if (cnt_q == TC_PERIODO) begin
                        salida_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    estado_d = REPOSO;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    assign sostenido = sostenido_q;
`else
    typedef enum logic {
        REPOSO = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    estado_t estado_q, estado_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= REPOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // ESPERA simply waits for release; no repeats in this build
    always_comb begin
        estado_d = estado_q;
        salida_d = 1'b0;
        if (!habilitar || !entrada) begin
            estado_d = REPOSO;
        end else if (estado_q == REPOSO && !entrada_q) begin
            salida_d = 1'b1;
            estado_d = ESPERA;
        end
    end

    assign sostenido = 1'b0;
`endif

endmodule
